// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory arbiter.
// Funct3 codes, owner tags and the response register layout.
package mem_arb_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e     owner;
    logic       valid;
    logic [2:0] funct3;
    logic [1:0] off;
    logic       err;
  } resp_t;

endpackage

// File: rtl/mem_arbiter_lsu_format.sv
// Load/store formatting: store lane shift and byte mask,
// misalignment check, load byte/half extract and extension.
module lsu_format
  import mem_arb_pkg::*;
(
  input  logic        st_we,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_wd,
  output logic [3:0]  st_mask,
  output logic        st_misal,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] sh;

  always_comb begin
    st_wd    = st_wdata;
    st_mask  = 4'b0000;
    st_misal = 1'b1;
    case (st_funct3)
      F3_B: begin
        st_misal = 1'b0;
        st_mask  = 4'b0001 << st_off;
        st_wd    = {4{st_wdata[7:0]}};
      end
      F3_H: begin
        st_misal = st_off[0];
        st_mask  = 4'b0011 << st_off;
        st_wd    = {2{st_wdata[15:0]}};
      end
      F3_W: begin
        st_misal = |st_off;
        st_mask  = 4'b1111;
      end
      // unsigned forms are load-only
      F3_BU:   st_misal = st_we;
      F3_HU:   st_misal = st_we | st_off[0];
      default: st_misal = 1'b1;
    endcase
  end

  always_comb begin
    sh      = ld_word >> {ld_off, 3'b000};
    ld_data = '0;
    case (ld_funct3)
      F3_B:    ld_data = {{24{sh[7]}}, sh[7:0]};
      F3_H:    ld_data = {{16{sh[15]}}, sh[15:0]};
      F3_W:    ld_data = ld_word;
      F3_BU:   ld_data = {24'h0, sh[7:0]};
      F3_HU:   ld_data = {16'h0, sh[15:0]};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: D-over-I priority with a
// starvation limit, one-cycle read response register.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rd
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  resp_t         resp_q, resp_d;
  logic          force_i;
  logic          st_misal;
  logic [31:0]   st_wd, ld_data;
  logic [3:0]    st_mask;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^i_addr[1:0];

  lsu_format u_fmt (
    .st_we     (d_we),
    .st_funct3 (d_funct3),
    .st_off    (d_addr[1:0]),
    .st_wdata  (d_wdata),
    .st_wd     (st_wd),
    .st_mask   (st_mask),
    .st_misal  (st_misal),
    .ld_funct3 (resp_q.funct3),
    .ld_off    (resp_q.off),
    .ld_word   (mem_rd),
    .ld_data   (ld_data)
  );

  always_comb begin
    force_i = i_req & (streak_q == STREAK_MAX);
    d_gnt   = ~reset & d_req & ~force_i;
    i_gnt   = ~reset & i_req & ~d_gnt;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_wd    = '0;
    mem_wmask = 4'b0000;
    if (d_gnt) begin
      mem_a = {d_addr[31:2], 2'b00};
      if (d_we & ~st_misal) begin
        mem_we    = 1'b1;
        mem_wd    = st_wd;
        mem_wmask = st_mask;
      end
    end else if (i_gnt) begin
      mem_a = {i_addr[31:2], 2'b00};
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (i_gnt | ~i_req) begin
      streak_d = '0;
    end else if (d_gnt & (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_comb begin
    resp_d        = '0;
    resp_d.owner  = OWN_I;
    if (d_gnt) begin
      resp_d.owner  = OWN_D;
      resp_d.valid  = ~d_we;
      resp_d.funct3 = d_funct3;
      resp_d.off    = d_addr[1:0];
      resp_d.err    = st_misal;
    end else if (i_gnt) begin
      resp_d.valid  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
      resp_q   <= '0;
    end else begin
      streak_q <= streak_d;
      resp_q   <= resp_d;
    end
  end

  // gate with reset so an in-flight read vanishes immediately
  always_comb begin
    i_rvalid = ~reset & resp_q.valid & (resp_q.owner == OWN_I);
    d_rvalid = ~reset & resp_q.valid & (resp_q.owner == OWN_D);
    d_err    = ~reset & resp_q.err & (resp_q.owner == OWN_D);
    i_rdata  = i_rvalid ? mem_rd : '0;
    d_rdata  = (d_rvalid & ~resp_q.err) ? ld_data : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-level reference memory and
// request-level arbitration model, directed plus random traffic.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [2:0]  d_funct3;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic [3:0]  mem_wmask;

  mem_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_wmask(mem_wmask), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  logic        pl_we;
  logic [7:0]  pl_idx;
  logic [31:0] pl_val;

  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_val;
    else if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_a[9:2]][8*b +: 8] <= mem_wd[8*b +: 8];
    mem_rd <= mem[mem_a[9:2]];
  end

  logic [7:0]  ref_b [0:1023];
  int          n_chk = 0;
  int          n_fail = 0;
  int          streak_m = 0;
  bit          exp_irv, exp_drv, exp_derr;
  logic [31:0] exp_ird, exp_drd;
  logic [3:0]  last_mask;
  logic [31:0] last_wd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_bad(input bit we, input logic [2:0] f3,
                                input logic [31:0] a);
    int off = int'(a[1:0]);
    case (f3)
      3'b000:  return 0;
      3'b001:  return off % 2 != 0;
      3'b010:  return off != 0;
      3'b100:  return we;
      3'b101:  return we || (off % 2 != 0);
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [31:0] a);
    int n = acc_size(f3);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_b[(int'(a[9:0]) + i) % 1024]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
    return v;
  endfunction

  task automatic cycle(input bit ir, input logic [31:0] ia,
                       input bit dr, input bit dw, input logic [2:0] f3,
                       input logic [31:0] da, input logic [31:0] wd,
                       output bit ig, output bit dg);
    bit          frc, eg_i, eg_d, bad, st_ok;
    int          n, off;
    logic [3:0]  em;
    logic [31:0] bm, ew;
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = dw; d_funct3 = f3; d_addr = da; d_wdata = wd;
    @(negedge clk);
    chk("i_rvalid", i_rvalid, 32'(exp_irv));
    if (exp_irv) chk("i_rdata", i_rdata, exp_ird);
    chk("d_rvalid", d_rvalid, 32'(exp_drv));
    chk("d_err", d_err, 32'(exp_derr));
    if (exp_drv || exp_derr) chk("d_rdata", d_rdata, exp_drd);
    frc  = ir && streak_m == 4;
    eg_d = dr && !frc;
    eg_i = ir && !eg_d;
    chk("d_gnt", d_gnt, 32'(eg_d));
    chk("i_gnt", i_gnt, 32'(eg_i));
    bad   = is_bad(dw, f3, da);
    st_ok = eg_d && dw && !bad;
    n     = acc_size(f3);
    off   = int'(da[1:0]);
    em = '0; bm = '0; ew = '0;
    if (st_ok)
      for (int i = 0; i < n; i++) begin
        em[off + i] = 1'b1;
        bm[8*(off+i) +: 8] = 8'hFF;
        ew[8*(off+i) +: 8] = wd[8*i +: 8];
      end
    chk("mem_we", mem_we, 32'(st_ok));
    chk("mem_wmask", mem_wmask, 32'(em));
    if (st_ok) chk("mem_wd", mem_wd & bm, ew & bm);
    if (eg_d) chk("mem_a", mem_a, da & ~32'h3);
    else if (eg_i) chk("mem_a", mem_a, ia & ~32'h3);
    else chk("mem_a", mem_a, 32'h0);
    last_mask = mem_wmask;
    last_wd   = mem_wd;
    exp_irv  = eg_i;
    exp_ird  = ref_load(3'b010, ia & ~32'h3);
    exp_drv  = eg_d && !dw;
    exp_derr = eg_d && bad;
    exp_drd  = (exp_drv && !bad) ? ref_load(f3, da) : 32'h0;
    if (st_ok)
      for (int i = 0; i < n; i++)
        ref_b[(int'(da[9:0]) + i) % 1024] = wd[8*i +: 8];
    if (eg_i || !ir) streak_m = 0;
    else if (eg_d && streak_m < 4) streak_m++;
    ig = eg_i; dg = eg_d;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bit a, b;
    cycle(0, 0, 0, 0, 3'b000, 0, 0, a, b);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_i_gnt"}, i_gnt, 0);
    chk({tag, "_d_gnt"}, d_gnt, 0);
    chk({tag, "_i_rvalid"}, i_rvalid, 0);
    chk({tag, "_d_rvalid"}, d_rvalid, 0);
    chk({tag, "_d_err"}, d_err, 0);
    chk({tag, "_i_rdata"}, i_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_wmask"}, mem_wmask, 0);
  endtask

  initial begin
    bit          ig, dg, ipend, dpend, dwe_r;
    logic [31:0] ia_r, da_r, wd_r, w;
    logic [2:0]  f3_r;
    logic [2:0]  f3_tab [0:6];
    int          n_d, n_i;
    f3_tab[0] = 3'b000; f3_tab[1] = 3'b001; f3_tab[2] = 3'b010;
    f3_tab[3] = 3'b100; f3_tab[4] = 3'b101; f3_tab[5] = 3'b011;
    f3_tab[6] = 3'b110;
    reset = 1'b1;
    i_req = 0; i_addr = 0; d_req = 1; d_we = 0;
    d_funct3 = 0; d_addr = 0; d_wdata = 0;
    pl_we = 1'b1; pl_idx = 0; pl_val = 0;
    exp_irv = 0; exp_drv = 0; exp_derr = 0; exp_ird = 0; exp_drd = 0;
    for (int k = 0; k < 256; k++) begin
      w = (k == 4) ? 32'hDEADBEEF : $urandom;
      pl_idx = 8'(k); pl_val = w;
      for (int b = 0; b < 4; b++) ref_b[4*k + b] = w[8*b +: 8];
      @(posedge clk); #1;
    end
    pl_we = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b0; d_req = 0;

    // 1: fetch
    cycle(1, 32'h10, 0, 0, 0, 0, 0, ig, dg);
    chk("t1_i_rvalid", i_rvalid, 1);
    chk("t1_i_rdata", i_rdata, 32'hDEADBEEF);
    // 2: SB then LB / LBU
    cycle(0, 0, 1, 1, 3'b000, 32'h23, 32'h000000A5, ig, dg);
    chk("t2_mask", last_mask, 4'b1000);
    chk("t2_wd", last_wd, 32'hA5A5A5A5);
    cycle(0, 0, 1, 0, 3'b000, 32'h23, 0, ig, dg);
    chk("t2_lb", d_rdata, 32'hFFFFFFA5);
    cycle(0, 0, 1, 0, 3'b100, 32'h23, 0, ig, dg);
    chk("t2_lbu", d_rdata, 32'h000000A5);
    // 3: contention pattern
    n_d = 0; n_i = 0;
    for (int k = 0; k < 15; k++) begin
      cycle(1, 32'h80 + 32'(4*k), 1, 0, 3'b010, 32'h100, 0, ig, dg);
      n_d += int'(dg); n_i += int'(ig);
    end
    chk("t3_d_grants", n_d, 12);
    chk("t3_i_grants", n_i, 3);
    idle();
    // 4: misaligned LW / SH
    cycle(0, 0, 1, 0, 3'b010, 32'h102, 0, ig, dg);
    chk("t4_err", d_err, 1);
    chk("t4_rvalid", d_rvalid, 1);
    chk("t4_rdata", d_rdata, 0);
    cycle(0, 0, 1, 1, 3'b001, 32'h101, 32'hFFFF, ig, dg);
    chk("t4_sh_err", d_err, 1);
    chk("t4_sh_rvalid", d_rvalid, 0);
    cycle(0, 0, 1, 0, 3'b010, 32'h100, 0, ig, dg);
    // 5: SW then LH
    cycle(0, 0, 1, 1, 3'b010, 32'h40, 32'h12345678, ig, dg);
    cycle(0, 0, 1, 0, 3'b001, 32'h42, 0, ig, dg);
    chk("t5_lh_hi", d_rdata, 32'h00001234);
    cycle(0, 0, 1, 0, 3'b001, 32'h40, 0, ig, dg);
    chk("t5_lh_lo", d_rdata, 32'h00005678);
    idle();
    // 6: reset with a load in flight
    cycle(0, 0, 1, 0, 3'b000, 32'h23, 0, ig, dg);
    reset = 1'b1;
    i_req = 1; d_req = 1;
    @(negedge clk);
    check_reset_outputs("t6");
    @(posedge clk); #1;
    reset = 1'b0;
    exp_irv = 0; exp_drv = 0; exp_derr = 0; streak_m = 0;
    idle();
    chk("t6_after", d_rvalid, 0);
    idle();
    // random traffic with held requests
    ipend = 0; dpend = 0;
    ia_r = 0; da_r = 0; wd_r = 0; f3_r = 0; dwe_r = 0;
    for (int k = 0; k < 400; k++) begin
      if (!ipend && ($urandom % 3 != 0)) begin
        ipend = 1; ia_r = 32'($urandom_range(0, 1023));
      end
      if (!dpend && ($urandom % 2 == 0)) begin
        dpend = 1;
        dwe_r = 1'($urandom);
        f3_r  = f3_tab[$urandom_range(0, 6)];
        da_r  = 32'h200 + 32'($urandom_range(0, 63));
        wd_r  = $urandom;
      end
      cycle(ipend, ia_r, dpend, dwe_r, f3_r, da_r, wd_r, ig, dg);
      if (ig) ipend = 0;
      if (dg) dpend = 0;
    end
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
